// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and handshake constants for memory-port requesters
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } eng_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // A request is accepted when its enable and mem_rdy are both high; one
    // mem_cplt strobe follows at least one cycle later, one transaction in flight.
    localparam int MEM_MAX_OUTSTANDING  = 1;
    localparam int MEM_MIN_CPLT_LATENCY = 1;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy/fill requester on one memory controller port
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] fill_val,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    input  logic                  mem_rdy,
    input  logic                  mem_cplt,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    eng_state_t            state, state_nxt;
    logic                  mode_reg;
    logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
    logic [LEN_WIDTH-1:0]  len_reg, words_inc;
    logic [DATA_WIDTH-1:0] fill_reg, data_buf;
    logic                  abort_pending;
    logic                  len0_hold;

    logic latch_job, capture_rd, wr_cplt, set_pend, finish_abort;

    assign words_inc = words_done + LEN_WIDTH'(1);

    always_comb begin
        state_nxt    = state;
        latch_job    = 1'b0;
        capture_rd   = 1'b0;
        wr_cplt      = 1'b0;
        set_pend     = 1'b0;
        finish_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    latch_job = 1'b1;
                    if (len == '0)             state_nxt = ST_DONE;
                    else if (mode == MODE_FILL) state_nxt = ST_WR_REQ;
                    else                        state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ, ST_WR_REQ: begin
                // An accepted request must finish; abort only cancels an unaccepted one.
                if (mem_rdy) begin
                    state_nxt = (state == ST_RD_REQ) ? ST_RD_WAIT : ST_WR_WAIT;
                    set_pend  = abort;
                end else if (abort) begin
                    state_nxt    = ST_DONE;
                    finish_abort = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (mem_cplt) begin
                    if (abort_pending || abort) begin
                        state_nxt    = ST_DONE;
                        finish_abort = 1'b1;
                    end else begin
                        capture_rd = 1'b1;
                        state_nxt  = ST_WR_REQ;
                    end
                end else begin
                    set_pend = abort;
                end
            end
            ST_WR_WAIT: begin
                if (mem_cplt) begin
                    wr_cplt = 1'b1;
                    if (abort_pending || abort) begin
                        state_nxt    = ST_DONE;
                        finish_abort = 1'b1;
                    end else if (words_inc == len_reg) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = (mode_reg == MODE_FILL) ? ST_WR_REQ : ST_RD_REQ;
                    end
                end else begin
                    set_pend = abort;
                end
            end
            ST_DONE: begin
                if (!len0_hold) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mode_reg      <= MODE_COPY;
            src_ptr       <= '0;
            dst_ptr       <= '0;
            len_reg       <= '0;
            fill_reg      <= '0;
            data_buf      <= '0;
            words_done    <= '0;
            aborted       <= 1'b0;
            abort_pending <= 1'b0;
            len0_hold     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_job) begin
                mode_reg      <= mode;
                src_ptr       <= src_addr;
                dst_ptr       <= dst_addr;
                len_reg       <= len;
                fill_reg      <= fill_val;
                words_done    <= '0;
                aborted       <= 1'b0;
                abort_pending <= 1'b0;
                len0_hold     <= (len == '0);
            end
            // A zero-length job spends one silent busy cycle before its done pulse.
            if (state == ST_DONE) len0_hold <= 1'b0;
            if (set_pend)     abort_pending <= 1'b1;
            if (capture_rd)   data_buf <= mem_data_out;
            if (finish_abort) aborted <= 1'b1;
            if (wr_cplt) begin
                words_done <= words_inc;
                src_ptr    <= src_ptr + ADDR_WIDTH'(1);
                dst_ptr    <= dst_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE) && !len0_hold;
    assign mem_r_en    = (state == ST_RD_REQ);
    assign mem_w_en    = (state == ST_WR_REQ);
    assign mem_addr    = (state == ST_RD_REQ || state == ST_RD_WAIT) ? src_ptr : dst_ptr;
    assign mem_data_in = (mode_reg == MODE_FILL) ? fill_reg : data_buf;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 16;
    localparam int K  = 2;

    logic          clk = 1'b0;
    logic          rst, start, mode, abort;
    logic [AW-1:0] src_addr, dst_addr;
    logic [LW-1:0] len;
    logic [DW-1:0] fill_val;
    logic          busy, done, aborted;
    logic [LW-1:0] words_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_r_en, mem_w_en, mem_rdy, mem_cplt;

    mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .words_done(words_done), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_rdy(mem_rdy),
        .mem_cplt(mem_cplt), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          exp_q[$];
    txn_t          e;
    logic [DW-1:0] mem[256];
    int            accept_cnt = 0, rd_acc = 0, en_cycles = 0, done_cnt = 0, done_cyc = 0;
    logic          done_aborted;
    logic [LW-1:0] done_words;
    int            stall_left = 0, cpl_cnt = 0;
    logic [DW-1:0] rd_hold = '0;
    logic          en, prev_stall = 1'b0, prev_r = 1'b0, prev_w = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Responder plus compare process: inputs set and outputs checked mid-cycle.
    always @(negedge clk) begin
        mem_cplt = 1'b0;
        if (cpl_cnt > 0) begin
            cpl_cnt--;
            if (cpl_cnt == 0) begin
                mem_cplt     = 1'b1;
                mem_data_out = rd_hold;
            end
        end
        en      = mem_r_en || mem_w_en;
        mem_rdy = !(stall_left > 0 && en);
        if (!rst) begin
            chk("excl_en", {63'd0, mem_r_en && mem_w_en}, 64'd0);
            if (prev_stall) begin
                chk("held_addr", {56'd0, mem_addr}, {56'd0, prev_addr});
                chk("held_ren", {63'd0, mem_r_en}, {63'd0, prev_r});
                chk("held_wen", {63'd0, mem_w_en}, {63'd0, prev_w});
            end
            if (en) en_cycles++;
            if (en && mem_rdy) begin
                accept_cnt++;
                if (mem_r_en) rd_acc++;
                if (exp_q.size() == 0) begin
                    chk("extra_req", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_kind", {63'd0, mem_w_en}, {63'd0, e.wr});
                    chk("req_addr", {56'd0, mem_addr}, {56'd0, e.addr});
                    if (e.wr) chk("wr_data", {48'd0, mem_data_in}, {48'd0, e.data});
                end
                if (mem_w_en) mem[mem_addr] = mem_data_in;
                else          rd_hold = mem[mem_addr];
                cpl_cnt = K;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                done_aborted = aborted;
                done_words   = words_done;
            end
        end
        prev_stall = en && !mem_rdy;
        prev_addr  = mem_addr;
        prev_r     = mem_r_en;
        prev_w     = mem_w_en;
        if (stall_left > 0 && en) stall_left--;
    end

    int t;

    task automatic start_job(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [LW-1:0] n, input logic [DW-1:0] f);
        txn_t x;
        logic [AW-1:0] sa, da;
        @(posedge clk); #2;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_val = f;
        t = cyc;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + AW'(i);
            da = d + AW'(i);
            if (!m) begin
                x.wr = 1'b0; x.addr = sa; x.data = '0;
                exp_q.push_back(x);
            end
            x.wr = 1'b1; x.addr = da; x.data = m ? f : mem[sa];
            exp_q.push_back(x);
        end
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_cnt > d0) break;
        end
        chk({name, "_timeout"}, {63'd0, i < 300}, 64'd1);
        #2;
        chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_accepts(input int target);
        int i;
        for (i = 0; i < 200 && accept_cnt < target; i++) @(posedge clk);
        chk("accept_timeout", {63'd0, accept_cnt >= target}, 64'd1);
        #2;
    endtask

    int d0, r0, a0, e0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
        mem_rdy = 1'b1; mem_cplt = 1'b0; mem_data_out = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_aborted", {63'd0, aborted}, 64'd0);
        chk("rst_words", {48'd0, words_done}, 64'd0);
        chk("rst_en", {62'd0, mem_r_en, mem_w_en}, 64'd0);
        chk("rst_addr", {56'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {48'd0, mem_data_in}, 64'd0);
        rst = 1'b0;

        // copy len=3: 1 + 3*2*(K+1) = 19 cycles to done
        d0 = done_cnt;
        start_job(1'b0, 8'h40, 8'h80, 16'd3, 16'h0);
        wait_done("copy");
        chk("copy_done_cyc", 64'(done_cyc - t), 64'd19);
        chk("copy_words", {48'd0, done_words}, 64'd3);
        chk("copy_aborted", {63'd0, done_aborted}, 64'd0);
        chk("copy_q_left", 64'(exp_q.size()), 64'd0);
        chk("copy_done_once", 64'(done_cnt - d0), 64'd1);
        chk("copy_mem80", {48'd0, mem[8'h80]}, 64'h1040);
        chk("copy_mem82", {48'd0, mem[8'h82]}, 64'h1042);

        // fill len=4 wrapping at 0xFF: 1 + 4*(K+1) = 13
        d0 = done_cnt; r0 = rd_acc;
        start_job(1'b1, 8'h00, 8'hFE, 16'd4, 16'hBEEF);
        wait_done("fill");
        chk("fill_done_cyc", 64'(done_cyc - t), 64'd13);
        chk("fill_no_reads", 64'(rd_acc - r0), 64'd0);
        chk("fill_done_once", 64'(done_cnt - d0), 64'd1);
        chk("fill_words", {48'd0, done_words}, 64'd4);
        chk("fill_memFE", {48'd0, mem[8'hFE]}, 64'hBEEF);
        chk("fill_memFF", {48'd0, mem[8'hFF]}, 64'hBEEF);
        chk("fill_mem00", {48'd0, mem[8'h00]}, 64'hBEEF);
        chk("fill_mem01", {48'd0, mem[8'h01]}, 64'hBEEF);

        // 5-cycle stall on the read request: 1 + 5 + 2*(K+1) = 12
        r0 = rd_acc; a0 = accept_cnt;
        stall_left = 5;
        start_job(1'b0, 8'h10, 8'h20, 16'd1, 16'h0);
        wait_done("stall");
        chk("stall_done_cyc", 64'(done_cyc - t), 64'd12);
        chk("stall_reads", 64'(rd_acc - r0), 64'd1);
        chk("stall_accepts", 64'(accept_cnt - a0), 64'd2);
        chk("stall_mem20", {48'd0, mem[8'h20]}, 64'h1010);

        // abort during the second read's wait
        d0 = done_cnt; a0 = accept_cnt;
        start_job(1'b0, 8'h30, 8'h90, 16'd5, 16'h0);
        wait_accepts(a0 + 3);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        wait_done("abort");
        chk("abort_flag", {63'd0, done_aborted}, 64'd1);
        chk("abort_words", {48'd0, done_words}, 64'd1);
        chk("abort_q_left", 64'(exp_q.size()), 64'd7);
        chk("abort_no_wr91", {48'd0, mem[8'h91]}, 64'h1091);
        chk("abort_done_once", 64'(done_cnt - d0), 64'd1);
        chk("abort_held", {63'd0, aborted}, 64'd1);
        exp_q.delete();

        // zero length
        e0 = en_cycles;
        start_job(1'b0, 8'h00, 8'h00, 16'd0, 16'h0);
        chk("len0_busy", {63'd0, busy}, 64'd1);
        wait_done("len0");
        chk("len0_done_cyc", 64'(done_cyc - t), 64'd2);
        chk("len0_no_en", 64'(en_cycles - e0), 64'd0);
        chk("len0_aborted_clr", {63'd0, done_aborted}, 64'd0);

        // start while busy is ignored
        d0 = done_cnt;
        start_job(1'b0, 8'h50, 8'hA0, 16'd2, 16'h0);
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1; mode = 1'b1; dst_addr = 8'h00; len = 16'd7; fill_val = 16'h5555;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("busy_start");
        chk("bs_done_cyc", 64'(done_cyc - t), 64'd13);
        chk("bs_words", {48'd0, done_words}, 64'd2);
        chk("bs_q_left", 64'(exp_q.size()), 64'd0);
        chk("bs_done_once", 64'(done_cnt - d0), 64'd1);
        chk("bs_mem00", {48'd0, mem[8'h00]}, 64'hBEEF);

        // reset during a write wait; the late completion must be ignored
        d0 = done_cnt; a0 = accept_cnt;
        start_job(1'b0, 8'h60, 8'hB0, 16'd3, 16'h0);
        wait_accepts(a0 + 2);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_en", {62'd0, mem_r_en, mem_w_en}, 64'd0);
        @(posedge clk); #2;
        chk("rst_late_busy", {63'd0, busy}, 64'd0);
        chk("rst_late_en", {62'd0, mem_r_en, mem_w_en}, 64'd0);
        chk("rst_late_words", {48'd0, words_done}, 64'd0);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_still_idle", {63'd0, busy}, 64'd0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
